// File: rtl/kogge_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on both sides.
// Operands are registered, turned into P/G, then combined one prefix level per stage.
module kogge_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = LEVELS + 2;

    // Valid bits: [0] operand stage, [1] P/G stage, [2..LEVELS+1] prefix levels, [LAT] result.
    logic [LAT:0]       vld_reg;
    logic               stall;
    logic               advance;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               cin_reg;
    logic               sub_reg;

    logic [WIDTH-1:0]   b_eff;
    logic               c0_pg;
    logic [WIDTH-1:0]   p_pg;
    logic [WIDTH-1:0]   g_pg;

    logic [WIDTH-1:0]   g_reg  [0:LEVELS];
    logic [WIDTH-1:0]   p_reg  [0:LEVELS];
    logic [WIDTH-1:0]   po_reg [0:LEVELS];
    logic [LEVELS:0]    c0_reg;

    logic [WIDTH-1:0]   g_next [1:LEVELS];
    logic [WIDTH-1:0]   p_next [1:LEVELS];

    logic [WIDTH-1:0]   carry_into;
    logic [WIDTH-1:0]   sum_next;
    logic               cout_next;
    logic               ovf_next;

    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;
    logic               ovf_reg;

    // Global stall: the whole pipe freezes, bubbles included.
    assign out_valid = vld_reg[LAT];
    assign stall     = out_valid & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_reg <= '0;
        end else if (advance) begin
            vld_reg <= {vld_reg[LAT-1:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            a_reg   <= a;
            b_reg   <= b;
            cin_reg <= cin;
            sub_reg <= sub;
        end
    end

    // Subtraction is a + ~b + 1; the carry-in is folded into bit 0 as a generate.
    always_comb begin
        b_eff   = sub_reg ? ~b_reg : b_reg;
        c0_pg   = sub_reg | cin_reg;
        p_pg    = a_reg ^ b_eff;
        g_pg    = a_reg & b_eff;
        g_pg[0] = g_pg[0] | (p_pg[0] & c0_pg);
    end

    generate
        for (genvar gi = 1; gi <= LEVELS; gi++) begin : g_level
            localparam int SPAN = 1 << (gi - 1);
            for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
                if (gb >= SPAN) begin : g_combine
                    assign g_next[gi][gb] = g_reg[gi-1][gb] |
                                            (p_reg[gi-1][gb] & g_reg[gi-1][gb-SPAN]);
                    assign p_next[gi][gb] = p_reg[gi-1][gb] & p_reg[gi-1][gb-SPAN];
                end else begin : g_pass
                    assign g_next[gi][gb] = g_reg[gi-1][gb];
                    assign p_next[gi][gb] = p_reg[gi-1][gb];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (advance) begin
            g_reg[0]  <= g_pg;
            p_reg[0]  <= p_pg;
            po_reg[0] <= p_pg;
            c0_reg[0] <= c0_pg;
            for (int k = 1; k <= LEVELS; k++) begin
                g_reg[k]  <= g_next[k];
                p_reg[k]  <= p_next[k];
                po_reg[k] <= po_reg[k-1];
                c0_reg[k] <= c0_reg[k-1];
            end
        end
    end

    // After the last level, group G[i] is the carry out of bit i.
    always_comb begin
        carry_into = {g_reg[LEVELS][WIDTH-2:0], c0_reg[LEVELS]};
        sum_next   = po_reg[LEVELS] ^ carry_into;
        cout_next  = g_reg[LEVELS][WIDTH-1];
        ovf_next   = carry_into[WIDTH-1] ^ cout_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (advance) begin
            sum_reg  <= sum_next;
            cout_reg <= cout_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign sum  = out_valid ? sum_reg : '0;
    assign cout = out_valid & cout_reg;
    assign ovf  = out_valid & ovf_reg;

endmodule

// File: tb/tb_kogge_pipe.sv
// Bench for kogge_pipe: one instance per width, each driven by directed, backpressure,
// reset and random phases and checked against an arithmetic model with a FIFO scoreboard.
module tb_kogge_pipe;

    localparam int NW    = 6;
    localparam int NRAND = 10000;

    typedef struct {
        logic [63:0] op_a;
        logic [63:0] op_b;
        logic        cin;
        logic        sub;
        int          cyc;
        int          stl;
    } beat_t;

    logic         clk;
    int           tests = 0;
    int           fails = 0;
    logic [NW-1:0] done_vec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(int i);
        case (i)
            0:       return 2;
            1:       return 8;
            2:       return 13;
            3:       return 16;
            4:       return 32;
            default: return 64;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(int w);
        if (w >= 64) return '1;
        return (64'(1) << w) - 64'(1);
    endfunction

    // Returns {ovf, cout, sum} computed with plain wide arithmetic.
    function automatic logic [65:0] model(int w, logic [63:0] a, logic [63:0] b,
                                          logic cin, logic sub);
        logic [63:0] m, am, bm, s;
        logic [64:0] full;
        logic        c, co, ov;
        m    = mask_of(w);
        am   = a & m;
        bm   = (sub ? ~b : b) & m;
        c    = sub ? 1'b1 : cin;
        full = {1'b0, am} + {1'b0, bm} + 65'(c);
        s    = full[63:0] & m;
        co   = full[w];
        ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    function automatic logic [63:0] rnd_op(int w);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(7))
            0: r = '0;
            1: r = '1;
            2: r = 64'(1) << (w - 1);
            3: r = (64'(1) << (w - 1)) - 64'(1);
            default: ;
        endcase
        return r & mask_of(w);
    endfunction

    task automatic check(input string name, input int w,
                         input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s W=%0d got %h expected %h", name, w, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_w
            localparam int W    = width_of(gi);
            localparam int LATX = $clog2(W) + 2;

            logic         rst, in_valid, in_ready, cin, sub;
            logic         out_valid, out_ready, cout, ovf;
            logic [W-1:0] a, b, sum;
            logic         quiet;
            logic         done;
            beat_t        q[$];
            int           cyc = 0;
            int           stl = 0;
            logic         held_vld = 1'b0;
            logic [W+1:0] held;

            kogge_pipe #(.WIDTH(W)) dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid),
                .in_ready (in_ready),
                .a        (a),
                .b        (b),
                .cin      (cin),
                .sub      (sub),
                .out_valid(out_valid),
                .out_ready(out_ready),
                .sum      (sum),
                .cout     (cout),
                .ovf      (ovf)
            );

            assign done_vec[gi] = done;

            always @(posedge clk) cyc <= cyc + 1;

            // Scoreboard: the monitor samples at the falling edge, mid-cycle.
            always @(negedge clk) begin
                logic        stall_now;
                beat_t       e;
                logic [65:0] mdl;
                stall_now = out_valid && !out_ready;
                if (rst) begin
                    q.delete();
                    held_vld = 1'b0;
                end else begin
                    check("in_ready", W, 72'(in_ready), 72'(!stall_now));
                    if (held_vld)
                        check("hold", W, 72'({out_valid, cout, ovf, sum}), 72'({1'b1, held}));
                    if (!out_valid)
                        check("gate", W, 72'({cout, ovf, sum}), 72'(0));
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL spurious W=%0d got sum=%h cout=%0b expected no result",
                                     W, sum, cout);
                        end else begin
                            e   = q.pop_front();
                            mdl = model(W, e.op_a, e.op_b, e.cin, e.sub);
                            check("result", W, 72'({cout, ovf, sum}),
                                  72'({mdl[64], mdl[65], mdl[W-1:0]}));
                            check("latency", W, 72'(cyc - e.cyc), 72'(LATX + 1 + stl - e.stl));
                            if (!quiet)
                                $display("[TB] W=%0d a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b ovf=%0b lat=%0d",
                                         W, e.op_a[W-1:0], e.op_b[W-1:0], e.cin, e.sub,
                                         sum, cout, ovf, cyc - e.cyc - 1);
                        end
                    end
                    if (in_valid && in_ready)
                        q.push_back('{op_a: 64'(a), op_b: 64'(b), cin: cin, sub: sub,
                                      cyc: cyc, stl: stl});
                    held_vld = stall_now;
                    held     = {cout, ovf, sum};
                    if (stall_now) stl++;
                end
            end

            initial begin
                logic [63:0] m64, msb;
                int          sent, cycles;
                logic        need_new, bad;
                m64 = mask_of(W);
                msb = 64'(1) << (W - 1);
                done = 1'b0; quiet = 1'b0;
                rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
                out_ready = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                check("reset_state", W, 72'({out_valid, in_ready, cout, ovf, sum}),
                      72'({1'b0, 1'b1, 1'b0, 1'b0, W'(0)}));

                // Directed corner beats, back-to-back with no stalls.
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b1;
                    case (i)
                        0: begin a = W'(m64);       b = W'(1); cin = 1'b0; sub = 1'b0; end
                        1: begin a = W'(msb);       b = W'(1); cin = 1'b0; sub = 1'b1; end
                        2: begin a = '0;            b = W'(1); cin = 1'b1; sub = 1'b1; end
                        3: begin a = W'(m64);       b = '0;    cin = 1'b1; sub = 1'b0; end
                        default: begin a = W'(msb - 64'(1)); b = W'(1); cin = 1'b0; sub = 1'b0; end
                    endcase
                end
                @(posedge clk); #1 in_valid = 1'b0;
                repeat (LATX + 4) @(posedge clk);
                check("directed_drain", W, 72'(q.size()), 72'(0));

                // 20 beats with the output blocked for cycles 8..14.
                sent = 0; need_new = 1'b1;
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk); #1;
                    out_ready = !(c >= 8 && c <= 14);
                    if (sent < 20) begin
                        in_valid = 1'b1;
                        if (need_new) begin
                            a = W'(rnd_op(W)); b = W'(rnd_op(W));
                            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
                        end
                    end else begin
                        in_valid = 1'b0;
                    end
                    @(negedge clk);
                    need_new = in_valid && in_ready;
                    if (need_new) sent++;
                end
                check("bp_sent", W, 72'(sent), 72'(20));
                check("bp_drain", W, 72'(q.size()), 72'(0));

                // Reset lands on the fourth beat; nothing in flight may emerge.
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b1; a = W'(rnd_op(W)); b = W'(rnd_op(W));
                    cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
                    rst = (i == 3);
                end
                @(posedge clk); #1;
                rst = 1'b0; in_valid = 1'b0;
                bad = 1'b0;
                for (int i = 0; i < LATX + 4; i++) begin
                    @(negedge clk);
                    if (out_valid || sum != '0 || cout || ovf) bad = 1'b1;
                end
                check("rst_flush", W, 72'(bad), 72'(0));
                @(posedge clk); #1;
                in_valid = 1'b1; a = W'(rnd_op(W)); b = W'(rnd_op(W));
                cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
                @(posedge clk); #1 in_valid = 1'b0;
                repeat (LATX + 4) @(posedge clk);
                check("rst_recover", W, 72'(q.size()), 72'(0));

                // Random regression with random input gaps and output backpressure.
                quiet = 1'b1; sent = 0; cycles = 0; need_new = 1'b1;
                while (sent < NRAND && cycles < 40000) begin
                    @(posedge clk); #1;
                    in_valid  = ($urandom_range(3) != 0);
                    out_ready = ($urandom_range(3) != 0);
                    if (need_new) begin
                        a = W'(rnd_op(W)); b = W'(rnd_op(W));
                        cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
                    end
                    @(negedge clk);
                    need_new = in_valid && in_ready;
                    if (need_new) sent++;
                    cycles++;
                end
                check("rand_sent", W, 72'(sent), 72'(NRAND));
                @(posedge clk); #1;
                in_valid = 1'b0; out_ready = 1'b1;
                for (int i = 0; i < LATX + 20 && q.size() != 0; i++) @(posedge clk);
                #1;
                check("rand_drain", W, 72'(q.size()), 72'(0));
                $display("[TB] W=%0d random phase: %0d beats in %0d cycles", W, sent, cycles);
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        // Model pins from hand-computed cases: {ovf, cout, sum}.
        check("pin16_add",  16, 72'(model(16, 64'hFFFF, 64'h0001, 1'b0, 1'b0)), 72'({1'b0, 1'b1, 64'h0000}));
        check("pin16_sub1", 16, 72'(model(16, 64'h8000, 64'h0001, 1'b0, 1'b1)), 72'({1'b1, 1'b1, 64'h7FFF}));
        check("pin16_sub2", 16, 72'(model(16, 64'h0000, 64'h0001, 1'b0, 1'b1)), 72'({1'b0, 1'b0, 64'hFFFF}));
        check("pin13_cin",  13, 72'(model(13, 64'h1FFF, 64'h0000, 1'b1, 1'b0)), 72'({1'b0, 1'b1, 64'h0000}));
        check("pin13_ovf",  13, 72'(model(13, 64'h0FFF, 64'h0001, 1'b0, 1'b0)), 72'({1'b1, 1'b0, 64'h1000}));
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk);
            if (&done_vec) break;
        end
        if (!(&done_vec)) begin
            tests++;
            fails++;
            $display("FAIL timeout done=%b expected all ones", done_vec);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
